// File: rtl/unzigzag_pkg.sv
// Shared types and zigzag helpers for the streaming unzigzag block.
// Q (coefficient width) defaults to the `Q macro, or 12 when `Q is not defined.
`ifndef Q
`define Q 12
`endif

package unzigzag_pkg;

  localparam int unsigned COEF_W      = `Q;
  localparam int unsigned BLOCK_N     = 8;
  localparam int unsigned BLOCK_COEFS = BLOCK_N * BLOCK_N;

  typedef logic signed [COEF_W-1:0] coef_t;

  // Walk the zigzag path idx steps from (0,0). Even anti-diagonals move up-right,
  // odd ones move down-left, turning at the block edges.
  function automatic int zz_walk(input int idx, input int n, input bit want_row);
    int row;
    int col;
    row = 0;
    col = 0;
    for (int k = 0; k < 256; k++) begin
      if (k < idx) begin
        if (((row + col) % 2) == 0) begin
          if (col == n - 1) begin
            row = row + 1;
          end else if (row == 0) begin
            col = col + 1;
          end else begin
            row = row - 1;
            col = col + 1;
          end
        end else begin
          if (row == n - 1) begin
            col = col + 1;
          end else if (col == 0) begin
            row = row + 1;
          end else begin
            row = row + 1;
            col = col - 1;
          end
        end
      end
    end
    return want_row ? row : col;
  endfunction

  function automatic int zz_row(input int idx, input int n);
    return zz_walk(idx, n, 1'b1);
  endfunction

  function automatic int zz_col(input int idx, input int n);
    return zz_walk(idx, n, 1'b0);
  endfunction

endpackage

// File: rtl/zz_index_rom.sv
// Combinational zigzag-index to natural {row,col} lookup, elaborated from the
// package walk functions.
module zz_index_rom
  import unzigzag_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = $clog2(N * N),
  parameter int unsigned RC_W  = $clog2(N)
) (
  input  logic [CNT_W-1:0] idx,
  output logic [RC_W-1:0]  row,
  output logic [RC_W-1:0]  col
);

  logic [RC_W-1:0] row_tab [N*N];
  logic [RC_W-1:0] col_tab [N*N];

  for (genvar g = 0; g < N * N; g++) begin : g_tab
    assign row_tab[g] = RC_W'(zz_row(g, N));
    assign col_tab[g] = RC_W'(zz_col(g, N));
  end

  // Select the table entry; explicit compare keeps non-power-of-two N in range.
  always_comb begin
    row = '0;
    col = '0;
    for (int i = 0; i < N * N; i++) begin
      if (idx == CNT_W'(i)) begin
        row = row_tab[i];
        col = col_tab[i];
      end
    end
  end

endmodule

// File: rtl/unzigzag_stream.sv
// Streaming double-buffered unzigzag: coefficients arrive in zigzag order, are
// scattered into natural order in one of two ping-pong banks, and each complete
// block is presented in parallel downstream.
// Optional feature macro: UNZIGZAG_EOB_EN adds the in_eob early-completion input
// and zeroes each bank as it drains.
`ifndef Q
`define Q 12
`endif

module unzigzag_stream
  import unzigzag_pkg::*;
#(
  parameter int unsigned Q     = `Q,
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = $clog2(N * N)
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic signed [Q-1:0]                  in_coef,
`ifdef UNZIGZAG_EOB_EN
  input  logic                                 in_eob,
`endif
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic signed [N-1:0][N-1:0][Q-1:0]    out_block
);

  localparam int unsigned RC_W = $clog2(N);
  localparam int unsigned LAST = N * N - 1;

  logic                            wr_bank_q;
  logic                            rd_bank_q;
  logic [1:0]                      full_q;
  logic [CNT_W-1:0]                cnt_q;
  logic [N-1:0][N-1:0][Q-1:0]      bank_q [2];

  logic            accept;
  logic            drain;
  logic            complete;
  logic [RC_W-1:0] zz_r;
  logic [RC_W-1:0] zz_c;

  zz_index_rom #(
    .N    (N),
    .CNT_W(CNT_W),
    .RC_W (RC_W)
  ) u_rom (
    .idx(cnt_q),
    .row(zz_r),
    .col(zz_c)
  );

  // Handshakes come from registered state only; both are forced low during reset.
  assign in_ready  = reset_n & ~full_q[wr_bank_q];
  assign out_valid = reset_n & full_q[rd_bank_q];
  assign out_block = bank_q[rd_bank_q];

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;
`ifdef UNZIGZAG_EOB_EN
  assign complete = accept & ((cnt_q == CNT_W'(LAST)) | in_eob);
`else
  assign complete = accept & (cnt_q == CNT_W'(LAST));
`endif

  // Bank fill, completion and drain; completion and drain always hit different banks.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
      cnt_q     <= '0;
      bank_q[0] <= '0;
      bank_q[1] <= '0;
    end else begin
      if (accept) begin
        bank_q[wr_bank_q][zz_r][zz_c] <= in_coef;
        cnt_q <= complete ? '0 : cnt_q + CNT_W'(1);
      end
      if (complete) begin
        full_q[wr_bank_q] <= 1'b1;
        wr_bank_q         <= ~wr_bank_q;
      end
      if (drain) begin
        full_q[rd_bank_q] <= 1'b0;
        rd_bank_q         <= ~rd_bank_q;
`ifdef UNZIGZAG_EOB_EN
        // Zero on drain so a later early-EOB block reads 0 in unwritten slots.
        bank_q[rd_bank_q] <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_unzigzag_stream.sv
// Self-checking bench for unzigzag_stream: a queue-based block model plus
// directed scenarios with literal expectations.
module tb_unzigzag_stream;

  localparam int N  = 8;
  localparam int Q  = 12;
  localparam int NN = N * N;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [Q-1:0] in_coef = '0;
  logic in_ready;
  logic out_valid;
  logic signed [N-1:0][N-1:0][Q-1:0] out_block;

  logic in_valid4 = 1'b0;
  logic out_ready4 = 1'b0;
  logic signed [Q-1:0] in_coef4 = '0;
  logic in_ready4;
  logic out_valid4;
  logic signed [3:0][3:0][Q-1:0] out_block4;

  unzigzag_stream #(.Q(Q), .N(N)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_coef  (in_coef),
`ifdef UNZIGZAG_EOB_EN
    .in_eob   (1'b0),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_block(out_block)
  );

  unzigzag_stream #(.Q(Q), .N(4)) dut4 (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid4),
    .in_ready (in_ready4),
    .in_coef  (in_coef4),
`ifdef UNZIGZAG_EOB_EN
    .in_eob   (1'b0),
`endif
    .out_valid(out_valid4),
    .out_ready(out_ready4),
    .out_block(out_block4)
  );

  always #5 clock = ~clock;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  typedef logic signed [Q-1:0] blk_t [N][N];
  blk_t exp_q[$];
  blk_t cur;
  int cnt_m = 0;
  int zr[NN];
  int zc[NN];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Zigzag order by anti-diagonals: even diagonals bottom-to-top, odd top-to-bottom.
  function automatic void build_zz();
    int k;
    k = 0;
    for (int s = 0; s <= 2 * N - 2; s++) begin
      for (int j = 0; j < N; j++) begin
        int r;
        int c;
        r = ((s % 2) == 0) ? (N - 1 - j) : j;
        c = s - r;
        if (c >= 0 && c < N) begin
          zr[k] = r;
          zc[k] = c;
          k++;
        end
      end
    end
  endfunction

  // Per-cycle compare against the model, then advance the model by the
  // handshakes that the coming posedge will perform.
  always @(negedge clock) begin
    bit exp_rdy;
    bit exp_vld;
    exp_rdy = reset_n && (exp_q.size() < 2);
    exp_vld = reset_n && (exp_q.size() > 0);
    check("in_ready", int'(in_ready), int'(exp_rdy));
    check("out_valid", int'(out_valid), int'(exp_vld));
    if (exp_vld && out_valid) begin
      int bad_r;
      int bad_c;
      bad_r = -1;
      bad_c = -1;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          if (bad_r < 0 && $signed(out_block[r][c]) != exp_q[0][r][c]) begin
            bad_r = r;
            bad_c = c;
          end
        end
      end
      compared++;
      if (bad_r >= 0) begin
        mismatched++;
        $display("FAIL out_block[%0d][%0d]: got %0d, expected %0d (t=%0t)", bad_r, bad_c,
                 $signed(out_block[bad_r][bad_c]), exp_q[0][bad_r][bad_c], $time);
      end
    end
    if (!reset_n) begin
      exp_q.delete();
      cnt_m = 0;
    end else begin
      if (exp_vld && out_ready) void'(exp_q.pop_front());
      if (in_valid && exp_rdy) begin
        cur[zr[cnt_m]][zc[cnt_m]] = in_coef;
        cnt_m++;
        if (cnt_m == NN) begin
          exp_q.push_back(cur);
          cnt_m = 0;
        end
      end
    end
  end

  task automatic send(input int v);
    int t;
    in_valid = 1'b1;
    in_coef  = Q'(v);
    t = 0;
    @(negedge clock);
    while (!in_ready && t < 300) begin
      @(negedge clock);
      t++;
    end
    if (t >= 300) check("send_timeout", 0, 1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int e4[16];
    e4 = '{0, 1, 5, 6, 2, 4, 7, 12, 3, 8, 11, 13, 9, 10, 14, 15};
    build_zz();
    check("zz2_row", zr[2], 1);
    check("zz3_row", zr[3], 2);
    check("zz5_col", zc[5], 2);
    check("zz63_row", zr[63], 7);

    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_blk00", $signed(out_block[0][0]), 0);
    check("rst_blk77", $signed(out_block[7][7]), 0);
    @(posedge clock);
    #1;

    // Ramp block, downstream always ready.
    out_ready = 1'b1;
    for (int i = 0; i < NN; i++) send(i);
    @(negedge clock);
    check("t1_valid", int'(out_valid), 1);
    check("t1_b00", $signed(out_block[0][0]), 0);
    check("t1_b01", $signed(out_block[0][1]), 1);
    check("t1_b02", $signed(out_block[0][2]), 5);
    check("t1_b03", $signed(out_block[0][3]), 6);
    check("t1_b10", $signed(out_block[1][0]), 2);
    check("t1_b77", $signed(out_block[7][7]), 63);
    @(negedge clock);
    check("t1_drained", int'(out_valid), 0);
    repeat (2) @(posedge clock);
    #1;

    // Two blocks with downstream stalled, third block held off.
    out_ready = 1'b0;
    for (int b = 1; b <= 2; b++) begin
      for (int i = 0; i < NN; i++) send(b * 256 + i);
    end
    @(negedge clock);
    check("t2_full_rdy", int'(in_ready), 0);
    check("t2_full_vld", int'(out_valid), 1);
    fork
      begin
        for (int i = 0; i < NN; i++) send(768 + i);
      end
      begin
        repeat (4) @(posedge clock);
        #1 out_ready = 1'b1;
        @(negedge clock);
        check("t2_first_blk", $signed(out_block[0][0]), 256);
        check("t2_first_rdy", int'(in_ready), 0);
        @(negedge clock);
        check("t2_second_blk", $signed(out_block[0][0]), 512);
        check("t2_rdy_back", int'(in_ready), 1);
      end
    join
    repeat (3) @(posedge clock);
    #1;

    // Continuous stream with completion and drain overlapping.
    c0 = cyc;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < NN; i++) send(((b * 37 + i * 5) % 200) - 100);
    end
    check("t3_cycles", cyc - c0, 3 * NN);
    repeat (3) @(posedge clock);
    #1;

    // Reset mid-block, then a fresh block.
    out_ready = 1'b0;
    for (int i = 0; i < 30; i++) send(-i - 1);
    reset_n = 1'b0;
    @(negedge clock);
    check("t4_rst_vld", int'(out_valid), 0);
    check("t4_rst_rdy", int'(in_ready), 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    for (int i = 0; i < NN; i++) send(1000 - i);
    @(negedge clock);
    check("t4_vld", int'(out_valid), 1);
    check("t4_b00", $signed(out_block[0][0]), 1000);
    check("t4_b01", $signed(out_block[0][1]), 999);
    check("t4_b77", $signed(out_block[7][7]), 937);
    @(posedge clock);
    #1 out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // N=4 instance.
    in_valid4 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_coef4 = Q'(i);
      @(posedge clock);
      #1;
    end
    in_valid4 = 1'b0;
    @(negedge clock);
    check("t6_vld", int'(out_valid4), 1);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("t6_b%0d%0d", k / 4, k % 4), $signed(out_block4[k / 4][k % 4]), e4[k]);
    end

    repeat (2) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
